vc_alloc_requester: RTL

- Input-port-side initiator of the VC allocation lookup.
- Tracks per-input-VC packet state: a head flit triggers an allocation lookup. The assigned output VC and outport are held until the tail leaves.
- Owns output-VC ownership bits so two packets never share one (outport, VC) pair.
- Sits between route compute and switch allocation in each switch input port.

---
 rtl/vc_alloc_pkg.sv | 22 ++
 rtl/vc_rr_arbiter.sv | 33 +++
 rtl/vc_alloc_requester.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/vc_alloc_pkg.sv
// Shared types and helpers for the VC allocation requester and its arbiter.
package vc_alloc_pkg;

  localparam int DEF_NUM_OUTPORTS = 4;
  localparam int DEF_NUM_VCS      = 2;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_WAIT   = 2'd1;
  localparam logic [1:0] ST_ACTIVE = 2'd2;

  typedef enum logic [1:0] {
    IDLE   = ST_IDLE,
    WAIT   = ST_WAIT,
    ACTIVE = ST_ACTIVE
  } vc_state_e;

  // Index width that stays legal when a dimension collapses to a single entry.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/vc_rr_arbiter.sv
// Combinational round-robin pick over a request vector, starting at ptr_i.
module vc_rr_arbiter
  import vc_alloc_pkg::*;
#(
  parameter  int N = DEF_NUM_VCS,
  localparam int W = idx_width(N)
) (
  input  logic [N-1:0] req_i,
  input  logic [W-1:0] ptr_i,
  output logic [W-1:0] winner_o,
  output logic         any_o
);

  localparam logic [W:0] N_W = (W+1)'(N);

  logic [W:0] sum_s;
  logic [W:0] cand_s;

  // Walk downward so the candidate closest to ptr_i is written last and wins.
  always_comb begin
    winner_o = '0;
    sum_s    = '0;
    cand_s   = '0;
    for (int k = N - 1; k >= 0; k--) begin
      sum_s    = {1'b0, ptr_i} + (W+1)'(k);
      cand_s   = (sum_s >= N_W) ? (sum_s - N_W) : sum_s;
      winner_o = req_i[cand_s[W-1:0]] ? cand_s[W-1:0] : winner_o;
    end
  end

  assign any_o = |req_i;

endmodule

// File: rtl/vc_alloc_requester.sv
// Input-port VC allocation requester: per-input-VC IDLE/WAIT/ACTIVE tracking,
// one allocator lookup per cycle, output-VC ownership. Option: VC_ALLOC_STATS_EN.
module vc_alloc_requester
  import vc_alloc_pkg::*;
#(
  parameter  int NUM_OUTPORTS = DEF_NUM_OUTPORTS,
  parameter  int NUM_VCS      = DEF_NUM_VCS,
  localparam int OP_W         = idx_width(NUM_OUTPORTS),
  localparam int VC_W         = idx_width(NUM_VCS)
) (
  input  logic                      clk,
  input  logic                      n_rst,
  input  logic [NUM_VCS-1:0]        head_valid,
  input  logic [NUM_VCS*OP_W-1:0]   head_outport,
  input  logic [NUM_VCS-1:0]        tail_done,
  input  logic [NUM_OUTPORTS-1:0]   dateline_cfg,
  output logic                      req_valid,
  output logic [VC_W-1:0]           req_incoming_vc,
  output logic [OP_W-1:0]           req_outport,
  output logic [NUM_OUTPORTS-1:0]   req_dateline,
  input  logic [VC_W-1:0]           alloc_assigned_vc,
  output logic [NUM_VCS-1:0]        vc_valid,
  output logic [NUM_VCS*VC_W-1:0]   vc_assigned,
  output logic [NUM_VCS*OP_W-1:0]   vc_outport
`ifdef VC_ALLOC_STATS_EN
  ,
  output logic [15:0]               stall_count
`endif
);

  vc_state_e            state_q    [NUM_VCS];
  vc_state_e            state_d    [NUM_VCS];
  logic [OP_W-1:0]      outport_q  [NUM_VCS];
  logic [OP_W-1:0]      outport_d  [NUM_VCS];
  logic [VC_W-1:0]      assigned_q [NUM_VCS];
  logic [VC_W-1:0]      assigned_d [NUM_VCS];
  logic [NUM_VCS-1:0]   owned_q    [NUM_OUTPORTS];
  logic [NUM_VCS-1:0]   owned_d    [NUM_OUTPORTS];
  logic [NUM_VCS-1:0]   valid_q;
  logic [NUM_VCS-1:0]   valid_d;
  logic [VC_W-1:0]      rr_ptr_q;
  logic [VC_W-1:0]      rr_ptr_d;

  logic [NUM_VCS-1:0]   wait_vec_s;
  logic [VC_W-1:0]      win_s;
  logic                 any_s;
  logic [OP_W-1:0]      req_op_s;
  logic [VC_W-1:0]      req_vc_s;
  logic                 grant_s;

  // Collect the input VCs currently waiting for a lookup.
  always_comb begin
    wait_vec_s = '0;
    for (int i = 0; i < NUM_VCS; i++) begin
      wait_vec_s[i] = (state_q[i] == WAIT);
    end
  end

  vc_rr_arbiter #(
    .N (NUM_VCS)
  ) u_arb (
    .req_i    (wait_vec_s),
    .ptr_i    (rr_ptr_q),
    .winner_o (win_s),
    .any_o    (any_s)
  );

  // Present the winner's lookup; the allocator answers in the same cycle.
  always_comb begin
    if (any_s) begin
      req_vc_s = win_s;
      req_op_s = outport_q[win_s];
    end else begin
      req_vc_s = '0;
      req_op_s = '0;
    end
  end

  // A pair released this cycle still reads as owned, so a matching request stalls.
  assign grant_s = any_s && !owned_q[req_op_s][alloc_assigned_vc];

  // Per-VC next-state, ownership set on grant and clear on tail.
  always_comb begin
    state_d    = state_q;
    outport_d  = outport_q;
    assigned_d = assigned_q;
    valid_d    = valid_q;
    owned_d    = owned_q;
    for (int i = 0; i < NUM_VCS; i++) begin
      case (state_q[i])
        IDLE: begin
          if (head_valid[i]) begin
            state_d[i]   = WAIT;
            outport_d[i] = head_outport[i*OP_W +: OP_W];
          end else begin
            state_d[i]   = IDLE;
          end
        end
        WAIT: begin
          if (grant_s && (win_s == VC_W'(i))) begin
            state_d[i]                          = ACTIVE;
            valid_d[i]                          = 1'b1;
            assigned_d[i]                       = alloc_assigned_vc;
            owned_d[req_op_s][alloc_assigned_vc] = 1'b1;
          end else begin
            state_d[i] = WAIT;
          end
        end
        ACTIVE: begin
          if (tail_done[i]) begin
            state_d[i]                           = IDLE;
            valid_d[i]                           = 1'b0;
            owned_d[outport_q[i]][assigned_q[i]] = 1'b0;
          end else begin
            state_d[i] = ACTIVE;
          end
        end
        default: begin
          state_d[i] = IDLE;
          valid_d[i] = 1'b0;
        end
      endcase
    end
  end

  // Pointer advances past every looked-up VC, granted or stalled.
  always_comb begin
    if (any_s) begin
      rr_ptr_d = (win_s == VC_W'(NUM_VCS - 1)) ? '0 : (win_s + VC_W'(1));
    end else begin
      rr_ptr_d = rr_ptr_q;
    end
  end

  // State registers; reset drops every allocation and ownership bit at once.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      for (int i = 0; i < NUM_VCS; i++) begin
        state_q[i]    <= IDLE;
        outport_q[i]  <= '0;
        assigned_q[i] <= '0;
      end
      for (int p = 0; p < NUM_OUTPORTS; p++) begin
        owned_q[p] <= '0;
      end
      valid_q  <= '0;
      rr_ptr_q <= '0;
    end else begin
      state_q    <= state_d;
      outport_q  <= outport_d;
      assigned_q <= assigned_d;
      owned_q    <= owned_d;
      valid_q    <= valid_d;
      rr_ptr_q   <= rr_ptr_d;
    end
  end

`ifdef VC_ALLOC_STATS_EN
  logic [15:0] stall_cnt_q;
  logic [15:0] stall_cnt_d;

  // Saturating count of lookups that did not win an output VC.
  always_comb begin
    if (any_s && !grant_s && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
  end

  // Stall counter register.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      stall_cnt_q <= 16'd0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_count = stall_cnt_q;
`endif

  assign req_valid       = any_s;
  assign req_incoming_vc = req_vc_s;
  assign req_outport     = req_op_s;
  assign req_dateline    = dateline_cfg;
  assign vc_valid        = valid_q;

  for (genvar g = 0; g < NUM_VCS; g++) begin : g_flat
    assign vc_assigned[g*VC_W +: VC_W] = assigned_q[g];
    assign vc_outport[g*OP_W +: OP_W]  = outport_q[g];
  end

endmodule
